fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline. Owns the program counter, drives the word address into the instruction memory, and captures the returned instruction into the IF/ID pipeline register. Next-PC selection (sequential, branch, j/jal, jr) is resolved here from decode-stage decisions. Delay-slot semantics apply: the instruction after a control transfer always executes.

---
 rtl/fetch_stage_pkg.sv | 14 +
 rtl/fetch_stage_npc_calc.sv | 37 +++
 rtl/fetch_stage.sv | 88 ++++++++
 tb/tb_fetch_stage.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the MIPS instruction-fetch stage: next-PC select
// encodings, reset PC, instruction-memory depth and the nop word.
package fetch_stage_pkg;

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
  localparam int unsigned IM_WORDS         = 1024;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_npc_calc.sv
// Combinational next-PC selection: sequential, branch, j/jal and jr targets.
// Branch and jump targets come from the IF/ID copy of the control instruction.
module fetch_stage_npc_calc
  import fetch_stage_pkg::*;
(
  input  logic [31:0] pc_f,
  input  logic [31:0] pc_d,
  input  logic [25:0] jidx_d,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [31:0] rs_val_d,
  output logic [31:0] npc
);

  logic [31:0] seq_pc;
  logic [31:0] br_off;
  logic [31:0] br_pc;
  logic [31:0] j_pc;

  assign seq_pc = pc_f + 32'd4;
  // Immediate is the low half of the instruction; jidx_d carries bits [25:0].
  assign br_off = {{14{jidx_d[15]}}, jidx_d[15:0], 2'b00};
  assign br_pc  = pc_d + 32'd4 + br_off;
  assign j_pc   = {pc_d[31:28], jidx_d, 2'b00};

  always_comb begin
    npc = seq_pc;
    unique case (npc_sel)
      NPC_SEQ: npc = seq_pc;
      NPC_BR:  npc = br_taken ? br_pc : seq_pc;
      NPC_J:   npc = j_pc;
      NPC_JR:  npc = rs_val_d;
      default: npc = seq_pc;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and next-PC mux.
// Define FETCH_CHECK_EN to register a fetch-address fault flag (exc_d) with each instruction.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [31:0] rs_val_d,
  input  logic [31:0] instr_f,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        valid_d,
  output logic        exc_d
);

  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] pc_d_q;
  logic [31:0] pc8_q;
  logic        valid_q;
  logic [31:0] npc;
  logic [31:0] instr_in;

  fetch_stage_npc_calc u_npc_calc (
    .pc_f     (pc_q),
    .pc_d     (pc_d_q),
    .jidx_d   (instr_q[25:0]),
    .npc_sel  (npc_sel),
    .br_taken (br_taken),
    .rs_val_d (rs_val_d),
    .npc      (npc)
  );

`ifdef FETCH_CHECK_EN
  logic        fault;
  logic        exc_q;
  logic [31:0] pc_off;

  assign pc_off = pc_q - PC_RESET;
  assign fault  = (pc_q[1:0] != 2'b00) || (pc_q < PC_RESET) || ((pc_off >> 2) >= IM_WORDS);
  // A faulting fetch enters ID as a nop so it has no architectural effect.
  assign instr_in = fault ? NOP_WORD : instr_f;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exc_q <= 1'b0;
    end else if (!stall) begin
      exc_q <= fault;
    end
  end

  assign exc_d = exc_q;
`else
  assign instr_in = instr_f;
  assign exc_d    = 1'b0;
`endif

  // Stall freezes PC and IF/ID together; a pending redirect is re-evaluated afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= PC_RESET;
      instr_q <= NOP_WORD;
      pc_d_q  <= 32'd0;
      pc8_q   <= 32'd0;
      valid_q <= 1'b0;
    end else if (!stall) begin
      pc_q    <= npc;
      instr_q <= instr_in;
      pc_d_q  <= pc_q;
      pc8_q   <= pc_q + 32'd8;
      valid_q <= 1'b1;
    end
  end

  assign pc_f    = pc_q;
  assign instr_d = instr_q;
  assign pc_d    = pc_d_q;
  assign pc8_d   = pc8_q;
  assign valid_d = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboarded bench for fetch_stage: directed control-transfer cases plus random
// stalls/redirects checked against an architectural fetch model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  npc_sel;
  logic        br_taken;
  logic [31:0] rs_val_d;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc8_d;
  logic        valid_d;
  logic        exc_d;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] pc8;
    logic        valid;
    logic        exc;
  } exp_t;

  exp_t exp_q[$];

  // Architectural model state.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pcd;
  logic [31:0] m_pc8;
  logic        m_valid;
  logic        m_exc;

  fetch_stage dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .npc_sel  (npc_sel),
    .br_taken (br_taken),
    .rs_val_d (rs_val_d),
    .instr_f  (instr_f),
    .pc_f     (pc_f),
    .instr_d  (instr_d),
    .pc_d     (pc_d),
    .pc8_d    (pc8_d),
    .valid_d  (valid_d),
    .exc_d    (exc_d)
  );

  always #5 clk = ~clk;

  // Instruction memory: beq/jal planted for the directed cases, hashed words elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_3010: return 32'h1000_FFFC;  // beq $0,$0,-4
      32'h0000_3020: return 32'h0C00_0C40;  // jal 0x3100
      default:       return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
    endcase
  endfunction

  assign instr_f = mem_word(pc_f);

  function automatic logic addr_fault(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h3000) || ((a - 32'h3000) / 4 >= 1024);
  endfunction

  task automatic model_reset();
    m_pc = 32'h3000; m_instr = 0; m_pcd = 0; m_pc8 = 0; m_valid = 0; m_exc = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // Called at a negedge; applies inputs, advances the model, waits for the next negedge.
  task automatic step(input logic s, input logic [1:0] sel, input logic br,
                      input logic [31:0] rs);
    logic [31:0] npc;
    logic        flt;
    exp_t        e;
    stall = s; npc_sel = sel; br_taken = br; rs_val_d = rs;
    if (!s) begin
      case (sel)
        2'd1: npc = br ? m_pcd + 4 + {{16{m_instr[15]}}, m_instr[15:0]} * 4 : m_pc + 4;
        2'd2: npc = (m_pcd & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 4);
        2'd3: npc = rs;
        default: npc = m_pc + 4;
      endcase
`ifdef FETCH_CHECK_EN
      flt = addr_fault(m_pc);
`else
      flt = 1'b0;
`endif
      m_instr = flt ? 32'h0 : mem_word(m_pc);
      m_pcd   = m_pc;
      m_pc8   = m_pc + 8;
      m_valid = 1'b1;
      m_exc   = flt;
      m_pc    = npc;
    end
    e = '{pc: m_pc, instr: m_instr, pcd: m_pcd, pc8: m_pc8, valid: m_valid, exc: m_exc};
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: compares every pending expectation just after the edge it refers to.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({pc_f, instr_d, pc_d, pc8_d, valid_d, exc_d} !== e) begin
        n_bad++;
        $display("FAIL scoreboard: got pc_f=%08h instr_d=%08h pc_d=%08h pc8_d=%08h v=%b exc=%b, required pc_f=%08h instr_d=%08h pc_d=%08h pc8_d=%08h v=%b exc=%b",
                 pc_f, instr_d, pc_d, pc8_d, valid_d, exc_d,
                 e.pc, e.instr, e.pcd, e.pc8, e.valid, e.exc);
      end
    end
  end

  task automatic random_steps(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] rs;
      rs = 32'h3000 + 4 * $urandom_range(0, 1100);
      if ($urandom_range(0, 7) == 0) rs = rs + $urandom_range(1, 3);
      step(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), 1'($urandom), rs);
    end
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; npc_sel = 2'b00; br_taken = 1'b0; rs_val_d = 32'h0;
    model_reset();
    #12;
    check("reset pc_f", pc_f, 32'h3000);
    check("reset instr_d", instr_d, 32'h0);
    check("reset pc_d", pc_d, 32'h0);
    check("reset pc8_d", pc8_d, 32'h0);
    check("reset valid_d", {31'd0, valid_d}, 32'd0);
    check("reset exc_d", {31'd0, exc_d}, 32'd0);

    @(negedge clk);
    reset = 1'b1;
    step(0, 2'b00, 0, 0);
    check("seq pc_f 1", pc_f, 32'h3004);
    check("seq valid_d", {31'd0, valid_d}, 32'd1);
    check("seq instr_d", instr_d, mem_word(32'h3000));
    step(0, 2'b00, 0, 0);
    check("seq pc_f 2", pc_f, 32'h3008);
    step(0, 2'b00, 0, 0);
    step(0, 2'b00, 0, 0);
    step(0, 2'b00, 0, 0);
    check("beq in ID", pc_d, 32'h3010);
    step(0, 2'b01, 1, 0);
    check("beq target", pc_f, 32'h3004);
    check("beq delay slot", pc_d, 32'h3014);
    for (int i = 0; i < 8; i++) step(0, 2'b00, 0, 0);
    check("jal in ID", pc_d, 32'h3020);
    check("jal link", pc8_d, 32'h3028);
    step(0, 2'b10, 0, 0);
    check("jal target", pc_f, 32'h3100);
    step(1, 2'b11, 0, 32'h3050);
    step(1, 2'b11, 0, 32'h3050);
    check("stall pc_f", pc_f, 32'h3100);
    check("stall pc_d", pc_d, 32'h3024);
    step(0, 2'b11, 0, 32'h3050);
    check("jr target", pc_f, 32'h3050);
    step(0, 2'b11, 0, 32'h3052);
    check("jr unaligned", pc_f, 32'h3052);
    step(0, 2'b00, 0, 0);
    check("fault pc_d", pc_d, 32'h3052);
`ifdef FETCH_CHECK_EN
    check("fault exc_d", {31'd0, exc_d}, 32'd1);
    check("fault instr_d", instr_d, 32'h0);
`else
    check("no-check exc_d", {31'd0, exc_d}, 32'd0);
    check("no-check instr_d", instr_d, mem_word(32'h3052));
`endif
    step(0, 2'b11, 0, 32'h3000);

    random_steps(400);

    // Asynchronous reset between edges.
    #2 reset = 1'b0;
    #1;
    check("async pc_f", pc_f, 32'h3000);
    check("async valid_d", {31'd0, valid_d}, 32'd0);
    check("async instr_d", instr_d, 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    random_steps(100);

    @(posedge clk);
    #3;
    check("queue drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
